cache_control: RTL and testbench

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/cache_control_pkg.sv | 29 ++
 rtl/cache_control_sat_counter.sv | 38 +++
 rtl/cache_control.sv | 173 +++++++++++++++++
 tb/tb_cache_control.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_control_pkg.sv
// Shared definitions for the cache controller slice.
// Holds the datapath mux select encodings and small decode helpers used by
// cache_control. The controller's state enum lives in cache_control itself.
package cache_control_pkg;

  // addressmux_sel encodings: CPU address, or the tag/index of one way.
  typedef enum logic [1:0] {
    ADDR_CPU  = 2'd0,
    ADDR_WAY0 = 2'd1,
    ADDR_WAY1 = 2'd2
  } addr_sel_e;

  // datainmux_sel encodings: whole line from memory, or merged CPU word.
  localparam logic DIN_PMEM = 1'b0;
  localparam logic DIN_CPU  = 1'b1;

  // Dirty bit of the way that would be evicted (lru = 1 means way1).
  function automatic logic victim_dirty(input logic lru,
                                        input logic dirty0,
                                        input logic dirty1);
    return lru ? dirty1 : dirty0;
  endfunction

  // Address select that presents the victim line's tag/index to memory.
  function automatic addr_sel_e victim_addr_sel(input logic lru);
    return lru ? ADDR_WAY1 : ADDR_WAY0;
  endfunction

endpackage

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter for controller performance statistics.
// Ports:
//   clk   - clock, counts on rising edge
//   reset - synchronous active-high clear
//   inc   - increment request for this cycle
//   count - current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative, write-back cache.
// Compares in S_CHECK, writes back a dirty victim in S_WB, fetches the line
// in S_FILL, then retries the request in S_CHECK where it hits.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   mem_read, mem_write, mem_resp - CPU request strobes / completion
//   pmem_read, pmem_write, pmem_resp - memory line strobes / done
//   hit0, hit1, dirty0_out, dirty1_out, lru_out - datapath status
//   datainmux_sel, addressmux_sel - datapath mux selects
//   load_*                        - datapath array write enables
//   hit_count, miss_count, wb_count - saturating performance counters
module cache_control
  import cache_control_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 hit0,
  input  logic                 hit1,
  input  logic                 dirty0_out,
  input  logic                 dirty1_out,
  input  logic                 lru_out,
  output logic                 datainmux_sel,
  output logic [1:0]           addressmux_sel,
  output logic                 load_dataarr0,
  output logic                 load_dataarr1,
  output logic                 load_valid0,
  output logic                 load_valid1,
  output logic                 load_tag0,
  output logic                 load_tag1,
  output logic                 load_dirty0,
  output logic                 load_dirty1,
  output logic                 load_lru,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [1:0] {
    S_CHECK = 2'd0,
    S_WB    = 2'd1,
    S_FILL  = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  logic req;
  logic miss_inc;
  logic wb_inc;

  assign req = mem_read | mem_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CHECK;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs depend on the current state and the same-cycle datapath status,
  // since hits must complete in the cycle they are detected.
  always_comb begin
    state_d        = state_q;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    datainmux_sel  = DIN_PMEM;
    addressmux_sel = ADDR_CPU;
    load_dataarr0  = 1'b0;
    load_dataarr1  = 1'b0;
    load_valid0    = 1'b0;
    load_valid1    = 1'b0;
    load_tag0      = 1'b0;
    load_tag1      = 1'b0;
    load_dirty0    = 1'b0;
    load_dirty1    = 1'b0;
    load_lru       = 1'b0;

    unique case (state_q)
      S_CHECK: begin
        if (req) begin
          if (hit0 | hit1) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            // mem_write wins over mem_read when both are high.
            if (mem_write) begin
              datainmux_sel = DIN_CPU;
              if (hit0) begin
                load_dataarr0 = 1'b1;
                load_dirty0   = 1'b1;
              end else begin
                load_dataarr1 = 1'b1;
                load_dirty1   = 1'b1;
              end
            end
          end else if (victim_dirty(lru_out, dirty0_out, dirty1_out)) begin
            state_d = S_WB;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      // The memory transaction runs to completion even if the CPU drops
      // its request meanwhile.
      S_WB: begin
        pmem_write     = 1'b1;
        addressmux_sel = victim_addr_sel(lru_out);
        if (pmem_resp) begin
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        pmem_read      = 1'b1;
        addressmux_sel = ADDR_CPU;
        datainmux_sel  = DIN_PMEM;
        if (pmem_resp) begin
          if (lru_out) begin
            load_dataarr1 = 1'b1;
            load_tag1     = 1'b1;
            load_valid1   = 1'b1;
            load_dirty1   = 1'b1;
          end else begin
            load_dataarr0 = 1'b1;
            load_tag0     = 1'b1;
            load_valid0   = 1'b1;
            load_dirty0   = 1'b1;
          end
          state_d = S_CHECK;
        end
      end

      default: begin
        state_d = S_CHECK;
      end
    endcase
  end

  assign miss_inc = (state_q == S_CHECK) && (state_d != S_CHECK);
  assign wb_inc   = (state_q == S_WB) && pmem_resp;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mem_resp),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc),
    .count (miss_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wb_inc),
    .count (wb_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control with 4-bit counters.
module tb_cache_control;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic          mem_read;
  logic          mem_write;
  logic          mem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic          pmem_resp;
  logic          hit0;
  logic          hit1;
  logic          dirty0_out;
  logic          dirty1_out;
  logic          lru_out;
  logic          datainmux_sel;
  logic [1:0]    addressmux_sel;
  logic          load_dataarr0;
  logic          load_dataarr1;
  logic          load_valid0;
  logic          load_valid1;
  logic          load_tag0;
  logic          load_tag1;
  logic          load_dirty0;
  logic          load_dirty1;
  logic          load_lru;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  logic [CW-1:0] wb_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_resp       (mem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_resp      (pmem_resp),
    .hit0           (hit0),
    .hit1           (hit1),
    .dirty0_out     (dirty0_out),
    .dirty1_out     (dirty1_out),
    .lru_out        (lru_out),
    .datainmux_sel  (datainmux_sel),
    .addressmux_sel (addressmux_sel),
    .load_dataarr0  (load_dataarr0),
    .load_dataarr1  (load_dataarr1),
    .load_valid0    (load_valid0),
    .load_valid1    (load_valid1),
    .load_tag0      (load_tag0),
    .load_tag1      (load_tag1),
    .load_dirty0    (load_dirty0),
    .load_dirty1    (load_dirty1),
    .load_lru       (load_lru),
    .hit_count      (hit_count),
    .miss_count     (miss_count),
    .wb_count       (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    hit0 = 1'b0; hit1 = 1'b0; dirty0_out = 1'b0; dirty1_out = 1'b0; lru_out = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_hit_count",  32'(hit_count),  0);
    check("rst_miss_count", 32'(miss_count), 0);
    check("rst_wb_count",   32'(wb_count),   0);
    check("rst_pmem_read",  32'(pmem_read),  0);
    check("rst_pmem_write", 32'(pmem_write), 0);
    check("rst_mem_resp",   32'(mem_resp),   0);

    // Read miss, clean victim way0.
    mem_read = 1'b1; lru_out = 1'b0; dirty0_out = 1'b0;
    #1;
    check("m1_check_resp",  32'(mem_resp),   0);
    check("m1_check_pread", 32'(pmem_read),  0);
    tick();
    check("m1_fill_pread",  32'(pmem_read),  1);
    check("m1_fill_pwrite", 32'(pmem_write), 0);
    check("m1_fill_amux",   32'(addressmux_sel), 0);
    check("m1_fill_dmux",   32'(datainmux_sel),  0);
    check("m1_fill_noload", 32'(load_dataarr0),  0);
    check("m1_miss_count",  32'(miss_count), 1);
    tick();
    check("m1_fill_wait",   32'(pmem_read),  1);
    pmem_resp = 1'b1;
    #1;
    check("m1_ld_data0",  32'(load_dataarr0), 1);
    check("m1_ld_tag0",   32'(load_tag0),     1);
    check("m1_ld_valid0", 32'(load_valid0),   1);
    check("m1_ld_dirty0", 32'(load_dirty0),   1);
    check("m1_ld_data1",  32'(load_dataarr1), 0);
    tick();
    pmem_resp = 1'b0; hit0 = 1'b1;
    #1;
    check("m1_retry_resp",  32'(mem_resp),  1);
    check("m1_retry_lru",   32'(load_lru),  1);
    check("m1_retry_pread", 32'(pmem_read), 0);
    tick();
    check("m1_hit_count",  32'(hit_count),  1);
    check("m1_miss_count2", 32'(miss_count), 1);
    mem_read = 1'b0; hit0 = 1'b0;

    // Read miss, dirty victim way1.
    lru_out = 1'b1; dirty1_out = 1'b1; mem_read = 1'b1;
    tick();
    check("m2_wb_pwrite", 32'(pmem_write),     1);
    check("m2_wb_amux",   32'(addressmux_sel), 2);
    check("m2_wb_pread",  32'(pmem_read),      0);
    check("m2_miss_count", 32'(miss_count),    2);
    tick();
    check("m2_wb_wait",   32'(pmem_write),     1);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    #1;
    check("m2_fill_pread",  32'(pmem_read),  1);
    check("m2_fill_pwrite", 32'(pmem_write), 0);
    check("m2_wb_count",    32'(wb_count),   1);
    pmem_resp = 1'b1;
    #1;
    check("m2_ld_data1", 32'(load_dataarr1), 1);
    check("m2_ld_tag1",  32'(load_tag1),     1);
    tick();
    pmem_resp = 1'b0; mem_read = 1'b0; dirty1_out = 1'b0;
    #1;
    check("m2_back_pread",  32'(pmem_read),  0);
    check("m2_back_pwrite", 32'(pmem_write), 0);

    // Write hit in way1.
    mem_write = 1'b1; hit1 = 1'b1;
    #1;
    check("w1_resp",   32'(mem_resp),      1);
    check("w1_dmux",   32'(datainmux_sel), 1);
    check("w1_data1",  32'(load_dataarr1), 1);
    check("w1_dirty1", 32'(load_dirty1),   1);
    check("w1_lru",    32'(load_lru),      1);
    check("w1_data0",  32'(load_dataarr0), 0);
    check("w1_pread",  32'(pmem_read),     0);
    check("w1_pwrite", 32'(pmem_write),    0);
    tick();
    mem_write = 1'b0; hit1 = 1'b1; hit1 = 1'b0;
    check("w1_hit_count", 32'(hit_count), 2);

    // Reset during fill.
    lru_out = 1'b0; dirty0_out = 1'b0; mem_read = 1'b1;
    tick();
    check("r_fill_pread", 32'(pmem_read), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_read = 1'b0;
    #1;
    check("r_pread",      32'(pmem_read),  0);
    check("r_pwrite",     32'(pmem_write), 0);
    check("r_hit_count",  32'(hit_count),  0);
    check("r_miss_count", 32'(miss_count), 0);
    check("r_wb_count",   32'(wb_count),   0);

    // 20 consecutive read hits saturate a 4-bit counter at 15.
    mem_read = 1'b1; hit0 = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_hit_14", 32'(hit_count), 14);
    for (int i = 0; i < 6; i++) tick();
    check("sat_hit_15", 32'(hit_count), 15);
    mem_read = 1'b0; hit0 = 1'b0;

    // Request dropped during fill; memory transaction still completes.
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    tick();
    check("d_fill_pread", 32'(pmem_read), 1);
    pmem_resp = 1'b1;
    #1;
    check("d_ld_data0", 32'(load_dataarr0), 1);
    tick();
    pmem_resp = 1'b0;
    #1;
    check("d_back_pread",  32'(pmem_read),  0);
    check("d_miss_count",  32'(miss_count), 1);

    // pmem_resp in S_CHECK with no request has no effect.
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    #1;
    check("idle_pread",  32'(pmem_read),  0);
    check("idle_pwrite", 32'(pmem_write), 0);

    // Both strobes high with a way0 hit is treated as a write.
    mem_read = 1'b1; mem_write = 1'b1; hit0 = 1'b1;
    #1;
    check("rw_resp",   32'(mem_resp),      1);
    check("rw_data0",  32'(load_dataarr0), 1);
    check("rw_dirty0", 32'(load_dirty0),   1);
    check("rw_dmux",   32'(datainmux_sel), 1);
    tick();
    mem_read = 1'b0; mem_write = 1'b0; hit0 = 1'b0;
    check("rw_hit_sat", 32'(hit_count), 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
